vga_sync_timer: RTL and testbench

- Timing master for the VGA path. Generates the raster position counters and the sync and blanking signals for a 640x480@60 display.
- Sits directly upstream of the pixel/colour generator. horizontalCount and verticalCount feed that stage; hsync and vsync go straight to the connector.
- Derives a pixel-rate enable from the system clock, so the whole VGA path runs on the single Clk domain.

---
 rtl/vga_sync_timer.sv | 116 +++++++++++
 tb/tb_vga_sync_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_timer.sv
// ----------------------------------------------------------------------------
// vga_sync_timer
// Raster timing master: pixel-rate prescaler, position counters, sync/blank.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_sync_timer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic       Clk,
  input  logic       vgaRes,
  output logic [9:0] horizontalCount,
  output logic [9:0] verticalCount,
  output logic       hsync,
  output logic       vsync,
  output logic       videoOn,
  output logic       pixelTick,
  output logic       frameStart
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] C_PS_LAST  = 4'(CLK_DIV - 1);
  localparam logic [9:0] C_H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] C_V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] C_H_VIS    = 10'(H_VIS);
  localparam logic [9:0] C_V_VIS    = 10'(V_VIS);
  localparam logic [9:0] C_HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] C_HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] C_VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] C_VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_tot_check
    $error("vga_sync_timer: H_TOT and V_TOT must each be <= 1024");
  end

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
    $error("vga_sync_timer: CLK_DIV must be in 1..16");
  end

  logic [3:0] ps_q, ps_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       von_q, von_d;
  logic       tick_q, tick_d;
  logic       fs_q, fs_d;
  logic       w_wrap;

  assign w_wrap = (ps_q == C_PS_LAST);

  // Decodes look at the next-state counters so they line up with the
  // counter values presented in the same cycle.
  always_comb begin
    ps_d   = w_wrap ? 4'd0 : ps_q + 4'd1;
    h_d    = h_q;
    v_d    = v_q;
    tick_d = w_wrap;
    fs_d   = w_wrap && (h_q == C_H_LAST) && (v_q == C_V_LAST);
    if (w_wrap) begin
      if (h_q == C_H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == C_V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    hs_d  = !((h_d >= C_HS_FIRST) && (h_d <= C_HS_LAST));
    vs_d  = !((v_d >= C_VS_FIRST) && (v_d <= C_VS_LAST));
    von_d = (h_d < C_H_VIS) && (v_d < C_V_VIS);
  end

  always_ff @(posedge Clk) begin
    if (!vgaRes) begin
      ps_q   <= 4'd0;
      h_q    <= 10'd0;
      v_q    <= 10'd0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      von_q  <= 1'b0;
      tick_q <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      h_q    <= h_d;
      v_q    <= v_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      von_q  <= von_d;
      tick_q <= tick_d;
      fs_q   <= fs_d;
    end
  end

  assign horizontalCount = h_q;
  assign verticalCount   = v_q;
  assign hsync           = hs_q;
  assign vsync           = vs_q;
  assign videoOn         = von_q;
  assign pixelTick       = tick_q;
  assign frameStart      = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_timer.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_timer
// Five timer instances with different geometries checked against a raster model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vga_sync_timer;

  typedef struct packed {
    int d; int hv; int hf; int hs; int hb; int vv; int vf; int vs; int vb;
  } cfg_t;

  typedef struct packed {
    longint h; longint v; logic hs; logic vs; logic von; logic pt; logic fs;
  } exp_t;

  localparam int NI = 5;
  // 0: default, 1: full size at CLK_DIV=1, 2: narrow lines at CLK_DIV=1,
  // 3: tiny raster, 4: narrow lines at CLK_DIV=3 used for the mid-frame reset.
  localparam cfg_t CFG [NI] = '{
    '{4, 640, 16, 96, 48, 480, 10, 2, 33},
    '{1, 640, 16, 96, 48, 480, 10, 2, 33},
    '{1,  16,  2,  4,  2, 480, 10, 2, 33},
    '{2,   8,  2,  2,  2,   4,  1, 1,  1},
    '{3,  16,  2,  4,  2, 480, 10, 2, 33}
  };

  logic       Clk = 1'b0;
  logic       rst_a;
  logic       rst_r;
  logic       chk_en;
  logic [9:0] hc  [NI];
  logic [9:0] vc  [NI];
  logic       hs  [NI];
  logic       vs  [NI];
  logic       von [NI];
  logic       pt  [NI];
  logic       fs  [NI];
  longint     n_cnt [NI];

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    vga_sync_timer #(
      .CLK_DIV(CFG[gi].d),
      .H_VIS(CFG[gi].hv), .H_FP(CFG[gi].hf), .H_SYNC(CFG[gi].hs), .H_BP(CFG[gi].hb),
      .V_VIS(CFG[gi].vv), .V_FP(CFG[gi].vf), .V_SYNC(CFG[gi].vs), .V_BP(CFG[gi].vb)
    ) u_dut (
      .Clk(Clk),
      .vgaRes((gi == 4) ? rst_r : rst_a),
      .horizontalCount(hc[gi]),
      .verticalCount(vc[gi]),
      .hsync(hs[gi]),
      .vsync(vs[gi]),
      .videoOn(von[gi]),
      .pixelTick(pt[gi]),
      .frameStart(fs[gi])
    );
  end

  // Released edges since the last reset edge, per instance.
  always @(posedge Clk) begin
    for (int i = 0; i < NI; i++) begin
      if ((i == 4) ? rst_r : rst_a) n_cnt[i] <= n_cnt[i] + 1;
      else                          n_cnt[i] <= 0;
    end
  end

  // After n released edges, floor(n/d) pixels have elapsed; position follows.
  function automatic exp_t model(input cfg_t c, input longint n);
    exp_t   e;
    longint ht, vt, ticks;
    ht    = c.hv + c.hf + c.hs + c.hb;
    vt    = c.vv + c.vf + c.vs + c.vb;
    ticks = n / c.d;
    e.h   = ticks % ht;
    e.v   = (ticks / ht) % vt;
    e.pt  = (n > 0) && ((n % c.d) == 0);
    e.fs  = e.pt && ((ticks % (ht * vt)) == 0);
    e.hs  = !((e.h >= c.hv + c.hf) && (e.h < c.hv + c.hf + c.hs));
    e.vs  = !((e.v >= c.vv + c.vf) && (e.v < c.vv + c.vf + c.vs));
    e.von = (n > 0) && (e.h < c.hv) && (e.v < c.vv);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, $signed(act), $signed(exp));
  endtask

  string NAMES [NI] = '{"def", "h1", "v", "s", "r"};

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        exp_t e;
        e = model(CFG[i], n_cnt[i]);
        chk({NAMES[i], ".hcount"},     64'(hc[i]),  64'(e.h));
        chk({NAMES[i], ".vcount"},     64'(vc[i]),  64'(e.v));
        chk({NAMES[i], ".hsync"},      64'(hs[i]),  64'(e.hs));
        chk({NAMES[i], ".vsync"},      64'(vs[i]),  64'(e.vs));
        chk({NAMES[i], ".videoOn"},    64'(von[i]), 64'(e.von));
        chk({NAMES[i], ".pixelTick"},  64'(pt[i]),  64'(e.pt));
        chk({NAMES[i], ".frameStart"}, 64'(fs[i]),  64'(e.fs));
      end
    end
  end

  // Measurements pinned against hand-computed numbers at the end of the run.
  longint first_fs [NI];
  int     hs_run = 0, hs_last_run = -1;
  int     hs_fall_h = -1, von_fall_h = -1;
  logic   hs1_prev = 1'b1, von1_prev = 1'b0;
  int     v_low_cnt = 0, tick_line0 = 0, fs_s_cnt = 0;
  int     h1_wrap_h = -1, h1_wrap_v = -1;

  initial for (int i = 0; i < NI; i++) first_fs[i] = -1;

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++)
        if (fs[i] === 1'b1 && first_fs[i] < 0) first_fs[i] = n_cnt[i];
      if (rst_a) begin
        if (hs[1] === 1'b0) hs_run++;
        else begin
          if (hs_run > 0) hs_last_run = hs_run;
          hs_run = 0;
        end
        if (hs1_prev && hs[1] === 1'b0 && hs_fall_h < 0) hs_fall_h = int'(hc[1]);
        if (von1_prev && von[1] === 1'b0 && von_fall_h < 0) von_fall_h = int'(hc[1]);
        hs1_prev  = hs[1];
        von1_prev = von[1];
        if (n_cnt[1] == 800) begin
          h1_wrap_h = int'(hc[1]);
          h1_wrap_v = int'(vc[1]);
        end
        if (n_cnt[2] >= 1 && n_cnt[2] <= 12600 && vs[2] === 1'b0) v_low_cnt++;
        if (n_cnt[0] >= 1 && n_cnt[0] <= 3200 && pt[0] === 1'b1) tick_line0++;
        if (n_cnt[3] >= 1 && n_cnt[3] <= 1960 && fs[3] === 1'b1) fs_s_cnt++;
      end
    end
  end

  initial begin
    rst_a  = 1'b0;
    rst_r  = 1'b0;
    chk_en = 1'b0;
    @(posedge Clk); #2;
    chk_en = 1'b1;
    repeat (5) @(posedge Clk);
    #2;
    chk("rst.hcount",     64'(hc[0]),  64'd0);
    chk("rst.vcount",     64'(vc[0]),  64'd0);
    chk("rst.hsync",      64'(hs[0]),  64'd1);
    chk("rst.vsync",      64'(vs[0]),  64'd1);
    chk("rst.videoOn",    64'(von[0]), 64'd0);
    chk("rst.pixelTick",  64'(pt[0]),  64'd0);
    chk("rst.frameStart", 64'(fs[0]),  64'd0);
    rst_a = 1'b1;
    rst_r = 1'b1;

    @(posedge Clk); #2;
    chk("rel.hcount",     64'(hc[0]),  64'd0);
    chk("rel.videoOn",    64'(von[0]), 64'd1);
    chk("rel.frameStart", 64'(fs[0]),  64'd0);
    chk("rel.pixelTick",  64'(pt[0]),  64'd0);
    chk("rel1.pixelTick", 64'(pt[1]),  64'd1);

    // 14462 released edges at CLK_DIV=3: pixel 4820 = (20,200), prescaler 2.
    repeat (14461) @(posedge Clk);
    #2;
    chk("mid.hcount", 64'(hc[4]), 64'd20);
    chk("mid.vcount", 64'(vc[4]), 64'd200);
    rst_r = 1'b0;
    @(posedge Clk); #2;
    chk("midrst.hcount",  64'(hc[4]),  64'd0);
    chk("midrst.vcount",  64'(vc[4]),  64'd0);
    chk("midrst.hsync",   64'(hs[4]),  64'd1);
    chk("midrst.videoOn", 64'(von[4]), 64'd0);
    @(posedge Clk); #2;
    rst_r = 1'b1;
    repeat (37805) @(posedge Clk);
    #2;

    chk("h1.hsync_run",     64'(hs_last_run), 64'd96);
    chk("h1.hsync_fall_h",  64'(hs_fall_h),   64'd656);
    chk("h1.video_fall_h",  64'(von_fall_h),  64'd640);
    chk("h1.wrap_h",        64'(h1_wrap_h),   64'd0);
    chk("h1.wrap_v",        64'(h1_wrap_v),   64'd1);
    chk("def.ticks_line0",  64'(tick_line0),  64'd800);
    chk("v.vsync_low",      64'(v_low_cnt),   64'd48);
    chk("v.first_frame",    64'(first_fs[2]), 64'd12600);
    chk("s.first_frame",    64'(first_fs[3]), 64'd196);
    chk("s.frames_1960",    64'(fs_s_cnt),    64'd10);
    chk("r.first_frame",    64'(first_fs[4]), 64'd37800);
    chk("h1.no_frame",      64'(first_fs[1]), -64'sd1);
    chk("def.no_frame",     64'(first_fs[0]), -64'sd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
